// File: rtl/huffman_decoder.sv
// huffman_decoder: loads a (symbol, length, codeword) table, then decodes a serial MSB-first bitstream into symbols over valid/ready.
module huffman_decoder #(
  parameter int SYM_W = 8,
  parameter int MAX_LEN = 8,
  parameter int TBL_DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int CW = $clog2(TBL_DEPTH) + 1
) (
  input  logic               i_clock,
  input  logic               i_rst_n,
  input  logic               i_tbl_valid,
  input  logic [SYM_W-1:0]   i_tbl_symbol,
  input  logic [3:0]         i_tbl_length,
  input  logic [MAX_LEN-1:0] i_tbl_code,
  input  logic               i_tbl_done,
  input  logic               i_tbl_clear,
  input  logic               i_bit_valid,
  input  logic               i_bit_in,
  output logic               o_bit_ready,
  output logic               o_sym_valid,
  output logic [SYM_W-1:0]   o_sym_out,
  input  logic               i_sym_ready,
  output logic               o_dec_error,
  output logic               o_tbl_overflow,
  output logic [CW-1:0]      o_tbl_count,
  output logic [CNT_W-1:0]   o_sym_count
);
  typedef enum logic [1:0] {LOAD, DECODE, OUTPUT, ERROR} state_t;
  state_t r_state, w_next;
  logic [SYM_W-1:0] r_tsym [TBL_DEPTH];
  logic [3:0] r_tlen [TBL_DEPTH];
  logic [MAX_LEN-1:0] r_tcode [TBL_DEPTH];
  logic [CW-1:0] r_count;
  logic r_ovf;
  logic [MAX_LEN-1:0] r_acc;
  logic [3:0] r_len;
  logic [SYM_W-1:0] r_sym_out;
  logic [CNT_W-1:0] r_sym_cnt;
  logic w_accept, w_hit, w_last, w_len_ok, w_full, w_write;
  logic [MAX_LEN-1:0] w_nacc, w_mask;
  logic [3:0] w_nlen;
  logic [SYM_W-1:0] w_hit_sym;
  assign w_accept = (r_state == DECODE) && i_bit_valid;
  assign w_nacc = {r_acc[MAX_LEN-2:0], i_bit_in};
  assign w_nlen = r_len + 4'd1;
  // Shifting by MAX_LEN yields an all-ones mask, covering full-length codes.
  assign w_mask = ~({MAX_LEN{1'b1}} << w_nlen);
  assign w_last = w_nlen == 4'(MAX_LEN);
  assign w_len_ok = (i_tbl_length != 4'd0) && (i_tbl_length <= 4'(MAX_LEN));
  assign w_full = r_count == CW'(TBL_DEPTH);
  assign w_write = (r_state == LOAD) && !i_tbl_clear && i_tbl_valid && w_len_ok && !w_full;
  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_hit_sym = '0;
    for (int i = TBL_DEPTH - 1; i >= 0; i--)
      if (CW'(i) < r_count && r_tlen[i] == w_nlen && ((r_tcode[i] ^ w_nacc) & w_mask) == '0) begin
        w_hit = 1'b1;
        w_hit_sym = r_tsym[i];
      end
  end
  always_comb begin
    w_next = r_state;
    if (i_tbl_clear) w_next = LOAD;
    else
      unique case (r_state)
        LOAD:    if (i_tbl_done) w_next = DECODE;
        DECODE:  if (w_accept) w_next = w_hit ? OUTPUT : w_last ? ERROR : DECODE;
        OUTPUT:  if (i_sym_ready) w_next = DECODE;
        default: w_next = ERROR;
      endcase
  end
  always_ff @(posedge i_clock or negedge i_rst_n)
    if (!i_rst_n) r_state <= LOAD;
    else r_state <= w_next;
  // Entries at or above r_count are invalid, so the table storage itself needs no reset.
  always_ff @(posedge i_clock)
    if (w_write) begin
      r_tsym[r_count[CW-2:0]] <= i_tbl_symbol;
      r_tlen[r_count[CW-2:0]] <= i_tbl_length;
      r_tcode[r_count[CW-2:0]] <= i_tbl_code;
    end
  always_ff @(posedge i_clock or negedge i_rst_n)
    if (!i_rst_n) begin
      r_count <= '0;
      r_ovf <= 1'b0;
      r_acc <= '0;
      r_len <= '0;
      r_sym_out <= '0;
      r_sym_cnt <= '0;
    end else if (i_tbl_clear) begin
      r_count <= '0;
      r_ovf <= 1'b0;
      r_acc <= '0;
      r_len <= '0;
      r_sym_cnt <= '0;
    end else begin
      if (w_write) r_count <= r_count + CW'(1);
      if (r_state == LOAD && i_tbl_valid && w_len_ok && w_full) r_ovf <= 1'b1;
      if (w_accept) begin
        r_acc <= (w_hit || w_last) ? '0 : w_nacc;
        r_len <= (w_hit || w_last) ? '0 : w_nlen;
        if (w_hit) r_sym_out <= w_hit_sym;
      end
      if (r_state == OUTPUT && i_sym_ready) r_sym_cnt <= r_sym_cnt + CNT_W'(1);
    end
  assign o_bit_ready = r_state == DECODE;
  assign o_sym_valid = r_state == OUTPUT;
  assign o_dec_error = r_state == ERROR;
  assign o_sym_out = r_sym_out;
  assign o_tbl_overflow = r_ovf;
  assign o_tbl_count = r_count;
  assign o_sym_count = r_sym_cnt;
endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed table-driven checks of huffman_decoder.
`timescale 1ns/1ps
module tb_huffman_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tbl_valid = 0, tbl_done = 0, tbl_clear = 0;
  logic [7:0] tbl_symbol = 0;
  logic [3:0] tbl_length = 0;
  logic [7:0] tbl_code = 0;
  logic bit_valid = 0, bit_in = 0, sym_ready = 0;
  logic bit_ready, sym_valid, dec_error, tbl_overflow;
  logic [7:0] sym_out;
  logic [4:0] tbl_count;
  logic [15:0] sym_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  huffman_decoder dut (
    .i_clock(clk), .i_rst_n(rst_n),
    .i_tbl_valid(tbl_valid), .i_tbl_symbol(tbl_symbol), .i_tbl_length(tbl_length),
    .i_tbl_code(tbl_code), .i_tbl_done(tbl_done), .i_tbl_clear(tbl_clear),
    .i_bit_valid(bit_valid), .i_bit_in(bit_in), .o_bit_ready(bit_ready),
    .o_sym_valid(sym_valid), .o_sym_out(sym_out), .i_sym_ready(sym_ready),
    .o_dec_error(dec_error), .o_tbl_overflow(tbl_overflow),
    .o_tbl_count(tbl_count), .o_sym_count(sym_count)
  );
  typedef struct {
    bit bv; bit b; bit sr;
    bit ev; logic [7:0] es; bit er; int ec;
  } vec_t;
  vec_t vt [18];
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic load(input logic [7:0] s, input logic [3:0] l, input logic [7:0] c);
    tbl_valid = 1; tbl_symbol = s; tbl_length = l; tbl_code = c;
    tick();
    tbl_valid = 0;
  endtask
  task automatic done();
    tbl_done = 1;
    tick();
    tbl_done = 0;
  endtask
  task automatic clear();
    tbl_clear = 1;
    tick();
    tbl_clear = 0;
  endtask
  task automatic send(input logic b);
    bit_valid = 1; bit_in = b;
    tick();
    bit_valid = 0;
  endtask
  initial begin
    vt[0]  = '{1, 0, 1, 1, 8'h41, 0, 0};
    vt[1]  = '{0, 0, 1, 0, 8'h00, 1, 1};
    vt[2]  = '{1, 1, 1, 0, 8'h00, 1, 1};
    vt[3]  = '{1, 0, 1, 1, 8'h42, 0, 1};
    vt[4]  = '{0, 0, 1, 0, 8'h00, 1, 2};
    vt[5]  = '{1, 1, 1, 0, 8'h00, 1, 2};
    vt[6]  = '{1, 1, 1, 1, 8'h43, 0, 2};
    vt[7]  = '{0, 0, 1, 0, 8'h00, 1, 3};
    vt[8]  = '{1, 0, 0, 1, 8'h41, 0, 3};
    vt[9]  = '{1, 1, 0, 1, 8'h41, 0, 3};
    vt[10] = '{1, 1, 0, 1, 8'h41, 0, 3};
    vt[11] = '{1, 1, 0, 1, 8'h41, 0, 3};
    vt[12] = '{1, 1, 0, 1, 8'h41, 0, 3};
    vt[13] = '{1, 1, 0, 1, 8'h41, 0, 3};
    vt[14] = '{0, 0, 1, 0, 8'h00, 1, 4};
    vt[15] = '{1, 1, 0, 0, 8'h00, 1, 4};
    vt[16] = '{1, 0, 0, 1, 8'h42, 0, 4};
    vt[17] = '{0, 0, 1, 0, 8'h00, 1, 5};
    #12;
    chk("rst bit_ready", bit_ready, 0);
    chk("rst sym_valid", sym_valid, 0);
    chk("rst sym_out", sym_out, 0);
    chk("rst dec_error", dec_error, 0);
    chk("rst tbl_count", tbl_count, 0);
    chk("rst sym_count", sym_count, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("load bit_ready", bit_ready, 0);
    load(8'h41, 1, 8'h00);
    load(8'h42, 2, 8'h02);
    load(8'h43, 2, 8'h03);
    chk("abc tbl_count", tbl_count, 3);
    done();
    chk("decode bit_ready", bit_ready, 1);
    for (int i = 0; i < 18; i++) begin
      bit_valid = vt[i].bv; bit_in = vt[i].b; sym_ready = vt[i].sr;
      tick();
      chk($sformatf("v%0d sym_valid", i), sym_valid, vt[i].ev);
      chk($sformatf("v%0d bit_ready", i), bit_ready, vt[i].er);
      chk($sformatf("v%0d sym_count", i), sym_count, vt[i].ec);
      if (vt[i].ev) chk($sformatf("v%0d sym_out", i), sym_out, vt[i].es);
    end
    bit_valid = 0; sym_ready = 1;
    chk("abc dec_error", dec_error, 0);
    clear();
    chk("clr sym_count", sym_count, 0);
    load(8'h41, 1, 8'h00);
    done();
    for (int k = 0; k < 8; k++) begin
      send(1);
      if (k < 7) begin
        chk($sformatf("ones%0d dec_error", k), dec_error, 0);
        chk($sformatf("ones%0d bit_ready", k), bit_ready, 1);
      end
    end
    chk("err dec_error", dec_error, 1);
    chk("err bit_ready", bit_ready, 0);
    chk("err sym_valid", sym_valid, 0);
    send(0);
    chk("err sticky", dec_error, 1);
    clear();
    chk("clr dec_error", dec_error, 0);
    chk("clr tbl_count", tbl_count, 0);
    chk("clr bit_ready", bit_ready, 0);
    for (int i = 0; i < 16; i++) load(8'(i), 8, 8'(i));
    chk("full tbl_count", tbl_count, 16);
    chk("full no ovf", tbl_overflow, 0);
    load(8'h99, 8, 8'hff);
    chk("ovf tbl_count", tbl_count, 16);
    chk("ovf tbl_overflow", tbl_overflow, 1);
    clear();
    chk("clr overflow", tbl_overflow, 0);
    load(8'h55, 0, 8'h00);
    load(8'h56, 9, 8'h00);
    chk("badlen tbl_count", tbl_count, 0);
    chk("badlen overflow", tbl_overflow, 0);
    clear();
    load(8'h45, 3, 8'h04);
    load(8'h41, 1, 8'h00);
    done();
    send(1);
    send(0);
    chk("pre-rst bit_ready", bit_ready, 1);
    rst_n = 0;
    #2;
    chk("arst bit_ready", bit_ready, 0);
    chk("arst sym_valid", sym_valid, 0);
    chk("arst sym_out", sym_out, 0);
    chk("arst tbl_count", tbl_count, 0);
    chk("arst dec_error", dec_error, 0);
    @(negedge clk);
    rst_n = 1;
    load(8'h45, 3, 8'h04);
    load(8'h41, 1, 8'h00);
    done();
    send(0);
    chk("no residue valid", sym_valid, 1);
    chk("no residue sym", sym_out, 8'h41);
    clear();
    tbl_valid = 1; tbl_symbol = 8'h44; tbl_length = 1; tbl_code = 8'h01; tbl_done = 1;
    tick();
    tbl_valid = 0; tbl_done = 0;
    chk("vd tbl_count", tbl_count, 1);
    chk("vd bit_ready", bit_ready, 1);
    send(1);
    chk("D sym_valid", sym_valid, 1);
    chk("D sym_out", sym_out, 8'h44);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
Inverse of the Huffman encoder. Loads a code table of (symbol, code length, codeword) entries, the same triple the encoder emits, then consumes a serial MSB-first bitstream. It emits one decoded symbol per matched codeword over a valid/ready handshake. It sits downstream of the encoder's table output and the compressed-bit source, and feeds the consumer of the original data.

Parameters:
SYM_W, 8, symbol width in bits
MAX_LEN, 8, maximum codeword length in bits; also the width of tbl_code
TBL_DEPTH, 16, number of code-table entries held
CNT_W, 16, width of the decoded-symbol counter

Ports:
clock  in  1  single clock; all logic on the rising edge
rst  in  1  reset; asynchronous assert, active-low
tbl_valid  in  1  table entry present on tbl_* this cycle
tbl_symbol  in  SYM_W  entry symbol
tbl_length  in  4  entry code length, 1..MAX_LEN
tbl_code  in  MAX_LEN  codeword right-aligned in tbl_code[len-1:0]; the first wire bit is tbl_code[len-1]
tbl_done  in  1  pulse: table complete, start decoding
tbl_clear  in  1  pulse: empty the table, clear the error and counter, return to LOAD
bit_valid  in  1  serial bit present
bit_in  in  1  serial data bit
bit_ready  out  1  decoder accepts a bit this cycle
sym_valid  out  1  decoded symbol available
sym_out  out  SYM_W  decoded symbol
sym_ready  in  1  consumer accepts sym_out
dec_error  out  1  sticky: invalid codeword prefix detected
tbl_overflow  out  1  sticky: table entry dropped because the table was full
tbl_count  out  $clog2(TBL_DEPTH)+1  entries currently loaded
sym_count  out  CNT_W  symbols emitted since the last clear; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst low, asynchronous):
  - State = LOAD. Table entries become invalid; tbl_count=0.
  - Accumulator acc=0; length counter len=0.
  - bit_ready=0, sym_valid=0, sym_out=0, dec_error=0, tbl_overflow=0, sym_count=0.
  - Reset mid-decode discards any partial codeword and any pending symbol.
- States: LOAD, DECODE, OUTPUT, ERROR.
- tbl_clear has priority over every other input in every state:
  - Next cycle: state=LOAD, all table entries invalid, tbl_count=0, acc=0, len=0, sym_valid=0.
  - dec_error, tbl_overflow and sym_count are cleared.
- LOAD:
  - bit_ready=0.
  - On tbl_valid with tbl_length in 1..MAX_LEN and tbl_count<TBL_DEPTH: write the entry at index tbl_count and increment tbl_count.
  - tbl_length of 0 or >MAX_LEN: the entry is ignored silently.
  - Table full: the entry is dropped and tbl_overflow is set.
  - tbl_done moves the state to DECODE. If tbl_valid and tbl_done arrive in the same cycle, the entry is written first, then the transition takes place.
- Decode datapath:
  - bit_ready=1 only in DECODE.
  - On accept (bit_valid & bit_ready): nacc={acc[MAX_LEN-2:0],bit_in}, nlen=len+1.
  - Combinational compare against every valid entry: hit when entry.length==nlen and entry.code[nlen-1:0]==nacc[nlen-1:0].
  - Multiple hits: the lowest table index wins.
- DECODE transitions on accept:
  - Hit: sym_out<=entry symbol, sym_valid<=1, acc<=0, len<=0, state<=OUTPUT. The symbol is visible the cycle after its last bit is accepted.
  - No hit and nlen<MAX_LEN: acc<=nacc, len<=nlen, stay in DECODE.
  - No hit and nlen==MAX_LEN: dec_error<=1, acc<=0, len<=0, state<=ERROR.
- tbl_valid and tbl_done are ignored outside LOAD.
- OUTPUT:
  - sym_valid held, sym_out stable, bit_ready=0.
  - On sym_ready: sym_valid<=0, sym_count<=sym_count+1, state<=DECODE.
  - Maximum throughput is one symbol per (code length + 1) cycles.
- ERROR: bit_ready=0, sym_valid=0. Exit only via tbl_clear or reset.
- Empty table in DECODE: every bit misses, so dec_error is set after MAX_LEN bits.

Test Plan:
- Load A=0x41 (len 1, code 0x00), B=0x42 (len 2, code 0x02), C=0x43 (len 2, code 0x03); pulse tbl_done; bits 0,1,0,1,1 with sym_ready=1 → sym_out 0x41, 0x42, 0x43 in order, each one cycle after its last bit; sym_count=3; dec_error=0.
- Same table, sym_ready held 0 for 5 cycles after A is decoded → sym_valid and sym_out=0x41 stable, bit_ready=0, no bits consumed; on sym_ready=1 decoding of B resumes.
- Table with only A (len 1, code 0x00); feed eight 1s → dec_error=1 after the 8th accept; bit_ready=0; then tbl_clear → state LOAD, dec_error=0, tbl_count=0.
- Load 17 valid entries with TBL_DEPTH=16 → tbl_count=16, tbl_overflow=1. An entry with tbl_length=0 → ignored, no overflow.
- Assert rst low after bits 1,0 of a len-3 code → all outputs return to reset values; after reload, the next symbol decodes from bit 0 with no residue.
- tbl_valid together with tbl_done (entry D=0x44, len 1, code 0x01) → tbl_count increments and state enters DECODE; bit 1 → sym_out=0x44.
